xalu_ctrl: RTL
==============

Name: xalu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO register owner for the E stage.
- Accepts the XALU_OP code issued by the E-stage controller: 2=mult, 3=multu, 4=div, 5=divu.
- Latches the operands and counts out a fixed latency, then commits the result to HI/LO.
- Drives busy so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO commit for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles from accepted start to HI/LO commit for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous reset, active-low
- start  in  1  E-stage instruction is a mult/div (XALU_OP nonzero and valid)
- XALU_OP  in  4  operation code as listed above
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- HI_WE  in  1  mthi write strobe
- LO_WE  in  1  mtlo write strobe
- wdata  in  32  mthi/mtlo data (rs)
- flush  in  1  exception/eret cancel of E stage
- busy  out  1  operation in flight
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, cnt=0, HI=0, LO=0, busy=0. Reset mid-operation aborts it with no commit.
- States: IDLE, RUN.
- IDLE -> RUN: requires start=1, flush=0 and XALU_OP in {2..5}.
  - Latch A, B and op.
  - Load cnt: MULT_CYCLES for op 2/3, DIV_CYCLES for op 4/5.
  - busy=1 from the next cycle.
- IDLE, start with any other op code: ignored.
- RUN: cnt decrements every cycle.
  - In the cycle with cnt==1: HI/LO commit at the edge, state returns to IDLE, busy=0 the following cycle.
  - Result visible on HI/LO exactly N cycles after the start edge (N = configured latency).
- Arithmetic on the latched operands:
  - mult: signed 32x32 -> 64, HI=product[63:32], LO=product[31:0].
  - multu: same, unsigned.
  - div: signed quotient/remainder truncated toward zero, LO=quotient, HI=remainder (sign of dividend).
  - divu: same, unsigned.
- Divide by zero (div or divu): LO=32'hFFFF_FFFF, HI=latched A. No exception raised.
- Signed overflow, div 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0.
- flush=1 in RUN: return to IDLE next edge, no commit, HI/LO unchanged.
- flush=1 together with start in IDLE: start ignored.
- HI_WE/LO_WE in IDLE: write wdata to HI/LO at the edge. HI_WE and LO_WE together write both.
- HI_WE/LO_WE in RUN: ignored. The hazard unit must stall mthi/mtlo while busy.
- HI_WE/LO_WE with flush=1: ignored.
- start and HI_WE/LO_WE in the same IDLE cycle: the move-to write happens, the operation starts, and the later commit overwrites it.
- start while busy: ignored, no queueing.
- HI/LO are registered outputs, readable every cycle. mfhi/mflo must be stalled by the hazard unit while busy.

Optional Feature:
- Macro: XALU_MADD_EN
- When defined:
  - XALU_OP 6=madd and 7=maddu are accepted and use MULT_CYCLES latency.
  - Commit {HI,LO} <= {HI,LO} + product. Signed product for madd, unsigned for maddu. 64-bit add, wrap modulo 2^64.
  - The {HI,LO} value used is the one at commit time.
- When not defined: ops 6/7 are treated as invalid and ignored in IDLE (no busy, no state change).

Test Plan:
- Signed multiply: reset, start op=2 with A=0xFFFF_FFFE (-2), B=3 -> busy high for 5 cycles; 5 cycles after start, HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; busy low on the next cycle.
- Signed divide: start op=4 with A=-7 (0xFFFF_FFF9), B=2 -> after 10 cycles LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). Repeat with op=5, A=7, B=2 -> LO=3, HI=1.
- Divide by zero: op=5, A=0x1234_5678, B=0 -> LO=0xFFFF_FFFF, HI=0x1234_5678. Signed overflow: op=4, A=0x8000_0000, B=0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- Flush mid-operation: HI_WE with wdata=0xAAAA_AAAA, LO_WE with wdata=0x5555_5555; then op=3 with A=B=0xFFFF_FFFF; assert flush in cycle 3 -> busy drops next cycle, HI/LO remain 0xAAAA_AAAA/0x5555_5555. Reset_n=0 mid-RUN gives the same abort with HI=LO=0.
- Back-to-back and ignored inputs: start again while busy, and HI_WE while busy -> both ignored, the first result commits correctly. Then start again in the first idle cycle -> accepted.
- With XALU_MADD_EN: set HI=0, LO=0xFFFF_FFFF, run op=7 with A=B=1 -> HI=1, LO=0. Without the macro: op=7 -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/xalu_ctrl.sv
// xalu_ctrl: multi-cycle multiply/divide sequencer and owner of the HI/LO
// registers for the E stage. An accepted op latches its operands and counts
// out a fixed latency. The result is then committed to HI/LO. busy lets the
// hazard unit stall mult/div/mfhi/mflo/mthi/mtlo.
// Optional feature macro: XALU_MADD_EN (adds madd=6 / maddu=7).
module xalu_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  XALU_OP,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HI_WE,
   input  logic        LO_WE,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'd2;
   localparam logic [3:0] OP_MULTU = 4'd3;
   localparam logic [3:0] OP_DIV   = 4'd4;
   localparam logic [3:0] OP_DIVU  = 4'd5;
`ifdef XALU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
`endif

   localparam logic [3:0] MUL_LAT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;

   // Decode of the incoming op code
   logic in_is_mul;
   logic in_is_div;
   logic in_valid;

   // Decode of the latched op code
   logic lat_signed;
   logic lat_div;
   logic lat_madd;

   // Datapath on the latched operands
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   // Classify the incoming op code
   always_comb begin
      in_is_mul = (XALU_OP == OP_MULT) || (XALU_OP == OP_MULTU);
`ifdef XALU_MADD_EN
      in_is_mul = in_is_mul || (XALU_OP == OP_MADD) || (XALU_OP == OP_MADDU);
`endif
      in_is_div = (XALU_OP == OP_DIV) || (XALU_OP == OP_DIVU);
      in_valid  = in_is_mul || in_is_div;
   end

   // Classify the latched op code
   always_comb begin
      lat_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
      lat_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
      lat_madd   = 1'b0;
`ifdef XALU_MADD_EN
      lat_signed = lat_signed || (op_q == OP_MADD);
      lat_madd   = (op_q == OP_MADD) || (op_q == OP_MADDU);
`endif
   end

   // Multiply: the low 64 bits of the sign/zero-extended product equal the
   // signed/unsigned 32x32 product
   always_comb begin
      mul_a   = {{32{lat_signed & a_q[31]}}, a_q};
      mul_b   = {{32{lat_signed & b_q[31]}}, b_q};
      product = mul_a * mul_b;
   end

   // Divide on magnitudes, then restore signs (truncate toward zero,
   // remainder takes the dividend's sign). 0x8000_0000 / -1 falls out as
   // quotient 0x8000_0000, remainder 0 through the wrap of the negation.
   always_comb begin
      a_neg = lat_signed & a_q[31];
      b_neg = lat_signed & b_q[31];
      a_mag = a_neg ? (32'd0 - a_q) : a_q;
      b_mag = b_neg ? (32'd0 - b_q) : b_q;
      q_mag = '0;
      r_mag = '0;
      if (b_mag != '0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem  = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   // Select the value committed to HI/LO
   always_comb begin
      res_hi = product[63:32];
      res_lo = product[31:0];
      if (lat_div) begin
         if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
         end else begin
            res_hi = rem;
            res_lo = quot;
         end
      end else if (lat_madd) begin
         {res_hi, res_lo} = {hi_q, lo_q} + product;
      end
   end

   // Sequencer next-state: accept in IDLE, count down in RUN, commit on cnt==1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (!flush) begin
               if (HI_WE) hi_d = wdata;
               if (LO_WE) lo_d = wdata;
               if (start && in_valid) begin
                  state_d = RUN;
                  op_d    = XALU_OP;
                  a_d     = A;
                  b_d     = B;
                  cnt_d   = in_is_div ? DIV_LAT : MUL_LAT;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = IDLE;
                  hi_d    = res_hi;
                  lo_d    = res_lo;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == RUN);
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
